// File: rtl/fpu_wb_queue.sv
// Writeback queue behind a fixed 4-cycle FPU: credits issue so every result finds a slot.
// Head fields come straight from storage (no bypass); a result pushed into a full queue is dropped and flagged.
module fpu_wb_queue #(
  parameter int LG_PRF_WIDTH = 4,
  parameter int LG_ROB_WIDTH = 4,
  parameter int LG_FCR_WIDTH = 4,
  parameter int LG_DEPTH     = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fpu_start,
  input  logic                    in_val,
  input  logic                    in_cmp_val,
  input  logic [63:0]             in_y,
  input  logic [LG_ROB_WIDTH-1:0] in_rob_ptr,
  input  logic [LG_PRF_WIDTH-1:0] in_dst_ptr,
  input  logic [LG_FCR_WIDTH-1:0] in_fcr_ptr,
  output logic                    can_issue,
  output logic                    out_val,
  output logic                    out_is_fcr,
  output logic [63:0]             out_y,
  output logic [LG_ROB_WIDTH-1:0] out_rob_ptr,
  output logic [LG_PRF_WIDTH-1:0] out_dst_ptr,
  output logic [LG_FCR_WIDTH-1:0] out_fcr_ptr,
  input  logic                    out_ack,
  output logic                    overflow,
  output logic                    tag_err
);

  localparam int N = 1 << LG_DEPTH;

  logic [3:0]            s;
  logic [LG_DEPTH:0]     count;
  logic [LG_DEPTH-1:0]   rd_ptr;
  logic [LG_DEPTH-1:0]   wr_ptr;
  logic [2:0]            inflight;
  logic [LG_DEPTH+1:0]   used;
  logic                  full;
  logic                  push;
  logic                  push_ok;
  logic                  pop;

  logic                    is_fcr_q [N];
  logic [63:0]             y_q      [N];
  logic [LG_ROB_WIDTH-1:0] rob_q    [N];
  logic [LG_PRF_WIDTH-1:0] dst_q    [N];
  logic [LG_FCR_WIDTH-1:0] fcr_q    [N];

  // Every op in the FPU pipe already owns a queue slot, so the pipe can never stall.
  assign inflight  = {2'b00, s[0]} + {2'b00, s[1]} + {2'b00, s[2]} + {2'b00, s[3]};
  assign used      = {1'b0, count} + (LG_DEPTH+2)'(inflight);
  assign can_issue = used < (LG_DEPTH+2)'(N);

  assign full    = (count == (LG_DEPTH+1)'(N));
  assign out_val = (count != '0);
  assign pop     = out_ack & out_val;
  assign push    = in_val | in_cmp_val;
  // A full queue still accepts when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop);

  assign out_is_fcr  = is_fcr_q[rd_ptr];
  assign out_y       = y_q[rd_ptr];
  assign out_rob_ptr = rob_q[rd_ptr];
  assign out_dst_ptr = dst_q[rd_ptr];
  assign out_fcr_ptr = fcr_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      s        <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
      tag_err  <= 1'b0;
    end else begin
      s <= {fpu_start, s[3:1]};
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push & ~push_ok)     overflow <= 1'b1;
      if (in_val & in_cmp_val) tag_err  <= 1'b1;
    end
  end

  // Storage is not reset; it is only observable through out_val-qualified fields.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      is_fcr_q[wr_ptr] <= in_cmp_val;
      y_q[wr_ptr]      <= in_y;
      rob_q[wr_ptr]    <= in_rob_ptr;
      dst_q[wr_ptr]    <= in_dst_ptr;
      fcr_q[wr_ptr]    <= in_fcr_ptr;
    end
  end

endmodule

// File: tb/tb_fpu_wb_queue.sv
// Scoreboard bench for fpu_wb_queue: stimulus queues expected writebacks, a monitor pops them on each handshake.
module tb_fpu_wb_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        fpu_start, in_val, in_cmp_val, out_ack;
  logic [63:0] in_y;
  logic [3:0]  in_rob_ptr, in_dst_ptr, in_fcr_ptr;
  logic        can_issue, out_val, out_is_fcr, overflow, tag_err;
  logic [63:0] out_y;
  logic [3:0]  out_rob_ptr, out_dst_ptr, out_fcr_ptr;

  always #5 clk = ~clk;

  fpu_wb_queue dut (
    .clk(clk), .reset(reset), .fpu_start(fpu_start),
    .in_val(in_val), .in_cmp_val(in_cmp_val), .in_y(in_y),
    .in_rob_ptr(in_rob_ptr), .in_dst_ptr(in_dst_ptr), .in_fcr_ptr(in_fcr_ptr),
    .can_issue(can_issue), .out_val(out_val), .out_is_fcr(out_is_fcr),
    .out_y(out_y), .out_rob_ptr(out_rob_ptr), .out_dst_ptr(out_dst_ptr),
    .out_fcr_ptr(out_fcr_ptr), .out_ack(out_ack),
    .overflow(overflow), .tag_err(tag_err)
  );

  typedef struct packed {
    logic        iv;
    logic        ic;
    logic [63:0] y;
    logic [3:0]  rob;
    logic [3:0]  dst;
    logic [3:0]  fcr;
  } res_t;

  res_t        fut [5];     // fut[k] = result the FPU delivers k cycles from now
  logic [76:0] sb [$];
  int          checks = 0;
  int          errors = 0;
  int          starts;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t mk(input logic iv, input logic ic, input logic [63:0] y,
                              input logic [3:0] rob, input logic [3:0] dst, input logic [3:0] fcr);
    res_t r;
    r.iv = iv; r.ic = ic; r.y = y; r.rob = rob; r.dst = dst; r.fcr = fcr;
    return r;
  endfunction

  task automatic clear_fut();
    for (int k = 0; k < 5; k++) fut[k] = '0;
  endtask

  // One cycle: drive inputs, record the expected entry unless it should be dropped, advance.
  task automatic step(input logic start, input res_t r, input logic ack, input bit drop);
    if (start) fut[4] = r;
    fpu_start  = start;
    out_ack    = ack;
    in_val     = fut[0].iv;
    in_cmp_val = fut[0].ic;
    in_y       = fut[0].y;
    in_rob_ptr = fut[0].rob;
    in_dst_ptr = fut[0].dst;
    in_fcr_ptr = fut[0].fcr;
    if ((fut[0].iv || fut[0].ic) && !drop && !reset)
      sb.push_back({fut[0].ic, fut[0].y, fut[0].rob, fut[0].dst, fut[0].fcr});
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) fut[k] = fut[k+1];
    fut[4]     = '0;
    fpu_start  = 1'b0;
    out_ack    = 1'b0;
    in_val     = 1'b0;
    in_cmp_val = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    clear_fut();
    sb.delete();
    repeat (n) step(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && out_val && out_ack) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected got %h with no entry expected at %0t", out_y, $time);
      end else begin
        logic [76:0] e;
        e = sb.pop_front();
        chk("wb_entry", {3'b000, out_is_fcr, out_y, out_rob_ptr, out_dst_ptr, out_fcr_ptr},
            {3'b000, e});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; fpu_start = 1'b0; in_val = 1'b0; in_cmp_val = 1'b0; out_ack = 1'b0;
    in_y = '0; in_rob_ptr = '0; in_dst_ptr = '0; in_fcr_ptr = '0;
    clear_fut();
    do_reset(2);
    chk("rst_out_val",   80'(out_val),   80'd0);
    chk("rst_can_issue", 80'(can_issue), 80'd1);
    chk("rst_overflow",  80'(overflow),  80'd0);
    chk("rst_tag_err",   80'(tag_err),   80'd0);

    // Single op through the 4-cycle FPU.
    step(1'b1, mk(1'b1, 1'b0, 64'h3FF0000000000000, 4'd5, 4'd2, 4'd0), 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0);
    chk("single_no_early", 80'(out_val), 80'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("single_out_val",  80'(out_val),    80'd1);
    chk("single_is_fcr",   80'(out_is_fcr), 80'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("single_drained",  80'(out_val),    80'd0);

    // Credit limit: issue whenever allowed, never acknowledge.
    starts = 0;
    for (int c = 0; c < 14; c++) begin
      logic st;
      st = can_issue;
      if (st) starts++;
      step(st, mk(1'b1, 1'b0, 64'hA000 + 64'(starts), 4'(starts), 4'(starts), 4'(starts)),
           1'b0, 1'b0);
      if (st && starts == 8) chk("credit_stop", 80'(can_issue), 80'd0);
    end
    chk("credit_starts",   80'(starts),    80'd8);
    chk("credit_overflow", 80'(overflow),  80'd0);
    chk("credit_full_val", 80'(out_val),   80'd1);
    chk("credit_full_ci",  80'(can_issue), 80'd0);

    // Full queue with simultaneous pop and push.
    fut[0] = mk(1'b1, 1'b0, 64'hBEEF, 4'd9, 4'd9, 4'd9);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("fullpop_overflow", 80'(overflow),  80'd0);
    chk("fullpop_ci",       80'(can_issue), 80'd0);

    // Forced overflow: the dropped result must never come out.
    fut[0] = mk(1'b1, 1'b0, 64'hDEAD, 4'd7, 4'd7, 4'd7);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("ovf_set", 80'(overflow), 80'd1);
    repeat (8) step(1'b0, '0, 1'b1, 1'b0);
    chk("ovf_drained", 80'(out_val),   80'd0);
    chk("ovf_sticky",  80'(overflow),  80'd1);
    chk("ovf_ci",      80'(can_issue), 80'd1);
    do_reset(1);
    chk("ovf_cleared", 80'(overflow),  80'd0);

    // Alternating PRF/FCR results, acked every cycle, across pointer wrap.
    for (int i = 0; i < 12; i++) begin
      fut[0] = mk(i % 2 == 0, i % 2 == 1, 64'h4000000000000000 | 64'(i),
                  4'(i), 4'(i + 3), 4'(15 - i));
      step(1'b0, '0, 1'b1, 1'b0);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    chk("alt_drained", 80'(out_val), 80'd0);
    chk("alt_no_tag",  80'(tag_err), 80'd0);
    fut[0] = mk(1'b1, 1'b1, 64'h5555, 4'd3, 4'd4, 4'd6);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("tag_err_set",  80'(tag_err),    80'd1);
    chk("tag_is_fcr",   80'(out_is_fcr), 80'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("tag_drained",  80'(out_val),    80'd0);

    // Reset with stored entries and ops in flight.
    do_reset(1);
    chk("tag_cleared", 80'(tag_err), 80'd0);
    for (int i = 0; i < 3; i++) begin
      fut[0] = mk(1'b1, 1'b0, 64'h7000 + 64'(i), 4'(i), 4'(i), 4'(i));
      step(1'b0, '0, 1'b0, 1'b0);
    end
    step(1'b1, mk(1'b1, 1'b0, 64'h7100, 4'd1, 4'd1, 4'd1), 1'b0, 1'b0);
    step(1'b1, mk(1'b1, 1'b0, 64'h7200, 4'd2, 4'd2, 4'd2), 1'b0, 1'b0);
    chk("mid_ci_before", 80'(can_issue), 80'd1);
    do_reset(1);
    chk("mid_out_val",   80'(out_val),   80'd0);
    chk("mid_can_issue", 80'(can_issue), 80'd1);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0);
    chk("mid_still_empty", 80'(out_val), 80'd0);
    fut[0] = mk(1'b1, 1'b0, 64'h0123456789ABCDEF, 4'd11, 4'd12, 4'd13);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("mid_sole_val", 80'(out_val), 80'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("mid_sole_gone", 80'(out_val), 80'd0);

    repeat (2) step(1'b0, '0, 1'b0, 1'b0);
    chk("sb_empty", 80'(sb.size()), 80'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_wb_queue.md
FPU_WB_QUEUE -- requirements
Module: fpu_wb_queue

Interface
REQ-001 Parameter LG_PRF_WIDTH, default 4, physical register pointer width.
REQ-002 Parameter LG_ROB_WIDTH, default 4, ROB pointer width.
REQ-003 Parameter LG_FCR_WIDTH, default 4, FCR pointer width.
REQ-004 Parameter LG_DEPTH, default 3, log2 of queue entries; N = 2**LG_DEPTH, N >= 5.
REQ-005 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1, synchronous, active-high reset.
REQ-007 Port fpu_start, input, 1, an op is issued to the FPU this cycle.
REQ-008 Port in_val, input, 1, FPU register result valid this cycle.
REQ-009 Port in_cmp_val, input, 1, FPU compare (FCR) result valid this cycle.
REQ-010 Port in_y, input, 64, FPU result data.
REQ-011 Ports in_rob_ptr / in_dst_ptr / in_fcr_ptr, input, LG_ROB_WIDTH / LG_PRF_WIDTH / LG_FCR_WIDTH, result tags.
REQ-012 Port can_issue, output, 1, scheduler may assert fpu_start this cycle.
REQ-013 Port out_val, output, 1, head entry valid.
REQ-014 Port out_is_fcr, output, 1, head entry targets FCR (1) or PRF (0).
REQ-015 Ports out_y / out_rob_ptr / out_dst_ptr / out_fcr_ptr, output, same widths as inputs, head entry fields.
REQ-016 Port out_ack, input, 1, writeback consumes head this cycle.
REQ-017 Port overflow, output, 1, sticky error: a result was dropped.
REQ-018 Port tag_err, output, 1, sticky error: in_val and in_cmp_val both high in one cycle.

Function
REQ-019 FPU latency is fixed at 4: fpu_start at cycle t implies its result (in_val or in_cmp_val) at cycle t+4; the FPU cannot be stalled.
REQ-020 Block keeps 4-bit shift register s: s[3] <= fpu_start, s[i-1] <= s[i]; s[0]=1 in the cycle the matching result arrives.
REQ-021 inflight = popcount(s[3:0]), range 0..4; count = stored entries, range 0..N.
REQ-022 can_issue = (count + inflight) < N, combinational, no dependence on out_ack.
REQ-023 Push condition: in_val | in_cmp_val; entry stores {in_cmp_val, in_y, rob, dst, fcr}.
REQ-024 Push accepted when count < N, or count == N and out_ack in the same cycle (pop-then-push).
REQ-025 Push not accepted: result dropped, overflow set to 1 and held until reset.
REQ-026 in_val & in_cmp_val both 1: tag_err set sticky; entry still pushed with out_is_fcr=1.
REQ-027 out_val = (count != 0); out_* fields reflect the head entry combinationally from storage; no input-to-output bypass (earliest output one cycle after push).
REQ-028 Pop on out_ack & out_val; out_ack with out_val=0 is ignored, no state change.
REQ-029 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-030 Read/write pointers are LG_DEPTH bits and wrap from N-1 to 0.
REQ-031 Strict FIFO order: entries leave in arrival order.
REQ-032 fpu_start while can_issue=0 is still shifted into s (tracked, not blocked).

Reset
REQ-033 While reset=1 at a rising edge: count=0, pointers=0, s=0, overflow=0, tag_err=0.
REQ-034 After reset: out_val=0, can_issue=1; entry storage is not reset and out_y/out_* are don't-care while out_val=0.
REQ-035 Reset mid-operation discards all stored entries and in-flight tracking; results arriving after reset are enqueued normally.

Verification
REQ-036 Single op: fpu_start at cycle 0; in_val, in_y=64'h3FF0000000000000, rob=5 at cycle 4 -> out_val=1 at cycle 5 with same data, out_is_fcr=0; out_ack at 5 -> out_val=0 at 6.
REQ-037 Credit limit (N=8): out_ack held 0, fpu_start every cycle while can_issue -> exactly 8 starts accepted, can_issue=0 from the cycle after the 8th start, overflow stays 0, 8 entries drain in order.
REQ-038 Full with pop: count=8, in_val and out_ack same cycle -> count stays 8, overflow=0, new entry last in order.
REQ-039 Forced overflow: count=8, out_ack=0, in_val=1 -> overflow=1, count=8, dropped result never appears; overflow remains 1 until reset.
REQ-040 Compare path and wrap: 12 alternating in_val/in_cmp_val pushes with out_ack every cycle -> out_is_fcr alternates 0,1, fcr_ptr/dst_ptr match inputs across pointer wrap; in_val&in_cmp_val together -> tag_err=1.
REQ-041 Reset mid-flight: 3 entries stored, 2 starts in flight, reset for one cycle -> out_val=0, can_issue=1, count=0; subsequent in_val enqueues as the sole entry.
